// File: rtl/doraemon_pkg.sv
// rtl/doraemon_pkg.sv - shared widths, record type and FSM states for the doraemon feeder
package doraemon_pkg;

    localparam int ID_W          = 5;
    localparam int SCORE_W       = 8;
    localparam int WGT_W         = 3;
    localparam int TOTAL_DEFAULT = 6000;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [SCORE_W-1:0] size;
        logic [SCORE_W-1:0] iq;
        logic [SCORE_W-1:0] eq;
        logic [WGT_W-1:0]   sw;
        logic [WGT_W-1:0]   iw;
        logic [WGT_W-1:0]   ew;
    } record_t;

    localparam int REC_W = $bits(record_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/doraemon_feeder_fifo.sv
// rtl/doraemon_feeder_fifo.sv - source-side record FIFO (DEPTH x 38, power-of-two depth)
module feeder_fifo
    import doraemon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [REC_W-1:0] wdata,
    output logic [REC_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/doraemon_feeder.sv
// rtl/doraemon_feeder.sv - issues buffered candidate records as single-cycle in_valid pulses
module doraemon_feeder
    import doraemon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TOTAL = TOTAL_DEFAULT,
    parameter int CW    = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [ID_W-1:0]    src_id,
    input  logic [SCORE_W-1:0] src_size,
    input  logic [SCORE_W-1:0] src_iq,
    input  logic [SCORE_W-1:0] src_eq,
    input  logic [WGT_W-1:0]   src_sw,
    input  logic [WGT_W-1:0]   src_iw,
    input  logic [WGT_W-1:0]   src_ew,
    input  logic               ready,
    output logic               in_valid,
    output logic [ID_W-1:0]    doraemon_id,
    output logic [SCORE_W-1:0] size,
    output logic [SCORE_W-1:0] iq_score,
    output logic [SCORE_W-1:0] eq_score,
    output logic [WGT_W-1:0]   size_weight,
    output logic [WGT_W-1:0]   iq_weight,
    output logic [WGT_W-1:0]   eq_weight,
    output logic [CW-1:0]      sent_cnt,
    output logic               done
);

    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

    record_t         src_rec, head;
    record_t         rec_q, rec_d;
    state_t          state_q, state_d;
    logic            in_valid_q, in_valid_d;
    logic            done_q, done_d;
    logic [CW-1:0]   sent_cnt_q, sent_cnt_d;
    logic            fifo_full, fifo_empty, push, pop;

    assign src_rec   = '{id: src_id, size: src_size, iq: src_iq, eq: src_eq,
                         sw: src_sw, iw: src_iw, ew: src_ew};
    assign src_ready = !fifo_full && !done_q;
    assign push      = src_valid && src_ready;

    feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (src_rec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // rec_d defaults to zero so the data outputs are 0 whenever in_valid is low.
    always_comb begin
        state_d    = state_q;
        rec_d      = '0;
        in_valid_d = 1'b0;
        sent_cnt_d = sent_cnt_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (sent_cnt_q == TOTAL_C) begin
                    state_d = DONE;
                end else if (ready && !fifo_empty) begin
                    rec_d      = head;
                    in_valid_d = 1'b1;
                    pop        = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = IDLE;
                if (sent_cnt_q != TOTAL_C) begin
                    sent_cnt_d = sent_cnt_q + CW'(1);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        // done rises with the count so it is visible the cycle after the last ISSUE.
        done_d = done_q || (sent_cnt_d == TOTAL_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rec_q      <= '0;
            in_valid_q <= 1'b0;
            sent_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            in_valid_q <= in_valid_d;
            sent_cnt_q <= sent_cnt_d;
            done_q     <= done_d;
        end
    end

    assign in_valid    = in_valid_q;
    assign doraemon_id = rec_q.id;
    assign size        = rec_q.size;
    assign iq_score    = rec_q.iq;
    assign eq_score    = rec_q.eq;
    assign size_weight = rec_q.sw;
    assign iq_weight   = rec_q.iw;
    assign eq_weight   = rec_q.ew;
    assign sent_cnt    = sent_cnt_q;
    assign done        = done_q;

endmodule

// File: tb/tb_doraemon_feeder.sv
// tb/tb_doraemon_feeder.sv - directed and random checks of doraemon_feeder against a queue model
module tb_doraemon_feeder;

    localparam int TOTAL_T = 8;
    localparam int DEPTH_T = 4;
    localparam int CW_T    = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            src_valid = 1'b0;
    logic            src_ready;
    logic [4:0]      src_id = '0;
    logic [7:0]      src_size = '0, src_iq = '0, src_eq = '0;
    logic [2:0]      src_sw = '0, src_iw = '0, src_ew = '0;
    logic            ready = 1'b0;
    logic            in_valid;
    logic [4:0]      doraemon_id;
    logic [7:0]      size, iq_score, eq_score;
    logic [2:0]      size_weight, iq_weight, eq_weight;
    logic [CW_T-1:0] sent_cnt;
    logic            done;

    doraemon_feeder #(.DEPTH(DEPTH_T), .TOTAL(TOTAL_T), .CW(CW_T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_id      (src_id),
        .src_size    (src_size),
        .src_iq      (src_iq),
        .src_eq      (src_eq),
        .src_sw      (src_sw),
        .src_iw      (src_iw),
        .src_ew      (src_ew),
        .ready       (ready),
        .in_valid    (in_valid),
        .doraemon_id (doraemon_id),
        .size        (size),
        .iq_score    (iq_score),
        .eq_score    (eq_score),
        .size_weight (size_weight),
        .iq_weight   (iq_weight),
        .eq_weight   (eq_weight),
        .sent_cnt    (sent_cnt),
        .done        (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          cyc = 0;
    int          first_pulse_cyc = -1;
    int          last_pulse_cyc = -1;
    logic [4:0]  last_id = '0;
    logic [37:0] last_rec = '0;
    logic [37:0] q[$];
    logic        exp_nv = 1'b0;
    bit          accepted = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: evaluate the model at the negedge, then return just after the next posedge.
    task automatic tick();
        int          fcnt;
        logic [37:0] exp_rec;
        logic [37:0] out_rec;
        @(negedge clk);
        cyc++;
        accepted = 0;
        if (!rst_n) begin
            q.delete();
            pulses = 0;
            exp_nv = 1'b0;
            first_pulse_cyc = -1;
            last_pulse_cyc = -1;
        end else begin
            out_rec = {doraemon_id, size, iq_score, eq_score, size_weight, iq_weight, eq_weight};
            fcnt = q.size() - (in_valid ? 1 : 0);
            check("in_valid", {63'd0, in_valid}, {63'd0, exp_nv});
            check("sent_cnt", {51'd0, sent_cnt}, 64'(pulses));
            check("done", {63'd0, done}, {63'd0, pulses == TOTAL_T});
            check("src_ready", {63'd0, src_ready},
                  {63'd0, (fcnt < DEPTH_T) && (pulses != TOTAL_T)});
            if (in_valid) begin
                if (q.size() == 0) begin
                    check("pulse_without_record", 64'd1, 64'd0);
                end else begin
                    exp_rec = q.pop_front();
                    check("record", {26'd0, out_rec}, {26'd0, exp_rec});
                end
                if (last_pulse_cyc >= 0) begin
                    check("pulse_gap", {63'd0, (cyc - last_pulse_cyc) >= 2}, 64'd1);
                end
                if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
                last_pulse_cyc = cyc;
                last_id = doraemon_id;
                last_rec = out_rec;
                pulses++;
            end else begin
                check("idle_data_zero", {26'd0, out_rec}, 64'd0);
            end
            if (src_valid && src_ready) begin
                q.push_back({src_id, src_size, src_iq, src_eq, src_sw, src_iw, src_ew});
                accepted = 1;
            end
            exp_nv = !in_valid && ready && (fcnt > 0) && (pulses < TOTAL_T);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [37:0] r);
        {src_id, src_size, src_iq, src_eq, src_sw, src_iw, src_ew} = r;
    endtask

    task automatic push_rec(input logic [37:0] r, input bit must);
        int n;
        set_src(r);
        src_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 20);
        src_valid = 1'b0;
        if (must) check("push_accept", {63'd0, accepted}, 64'd1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        src_valid = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [37:0] rand_rec(input logic [4:0] id);
        return {id, 8'($urandom), 8'($urandom), 8'($urandom),
                3'($urandom), 3'($urandom), 3'($urandom)};
    endfunction

    int base;

    initial begin
        // Reset state
        do_reset(3);
        tick();

        // Back-to-back records with ready high: pulses every other cycle
        ready = 1'b1;
        for (int i = 1; i <= 5; i++) push_rec(rand_rec(5'(i)), 1);
        repeat (12) tick();
        check("five_sent", {51'd0, sent_cnt}, 64'd5);
        check("five_last_id", {59'd0, last_id}, 64'd5);
        check("five_span", 64'(last_pulse_cyc - first_pulse_cyc), 64'd8);

        // Hold-off with a full FIFO, then a one-cycle ready window
        do_reset(1);
        ready = 1'b0;
        for (int i = 11; i <= 14; i++) push_rec(rand_rec(5'(i)), 1);
        repeat (4) tick();
        check("full_src_ready", {63'd0, src_ready}, 64'd0);
        check("held_no_pulse", 64'(pulses), 64'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (4) tick();
        check("window_one_pulse", 64'(pulses), 64'd1);
        check("window_oldest", {59'd0, last_id}, 64'd11);

        // Ready drops on the edge that ends an ISSUE cycle
        ready = 1'b1;
        base = pulses;
        for (int n = 0; n < 10 && pulses == base; n++) tick();
        ready = 1'b0;
        base = pulses;
        repeat (5) tick();
        check("drop_no_more", 64'(pulses - base), 64'd0);
        ready = 1'b1;
        repeat (6) tick();

        // Bit-exact record passthrough
        push_rec({5'd7, 8'd200, 8'd15, 8'd255, 3'd3, 3'd5, 3'd7}, 1);
        repeat (4) tick();
        check("exact_record", {26'd0, last_rec},
              {26'd0, 5'd7, 8'd200, 8'd15, 8'd255, 3'd3, 3'd5, 3'd7});

        // Reset mid-stream discards buffered records
        do_reset(1);
        ready = 1'b0;
        for (int i = 20; i <= 22; i++) push_rec(rand_rec(5'(i)), 1);
        do_reset(1);
        ready = 1'b1;
        repeat (4) tick();
        check("flushed_no_pulse", 64'(pulses), 64'd0);
        push_rec(rand_rec(5'd9), 1);
        repeat (4) tick();
        check("post_reset_first", {59'd0, last_id}, 64'd9);
        check("post_reset_cnt", {51'd0, sent_cnt}, 64'd1);

        // Saturation at TOTAL with extra records offered
        do_reset(1);
        ready = 1'b1;
        for (int i = 1; i <= 10; i++) push_rec(rand_rec(5'(i)), 0);
        repeat (20) tick();
        check("total_pulses", 64'(pulses), 64'(TOTAL_T));
        check("total_cnt", {51'd0, sent_cnt}, 64'(TOTAL_T));
        check("total_done", {63'd0, done}, 64'd1);
        check("total_src_ready", {63'd0, src_ready}, 64'd0);
        check("total_last_id", {59'd0, last_id}, 64'(TOTAL_T));

        // Random traffic against the model
        for (int r = 0; r < 3; r++) begin
            do_reset(1);
            for (int n = 0; n < 150; n++) begin
                ready = ($urandom_range(0, 3) > r[1:0]);
                src_valid = $urandom_range(0, 1) == 1;
                set_src(rand_rec(5'($urandom)));
                tick();
            end
            src_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
